// File: rtl/ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter with ACK check.
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 420,
  parameter int TIMEOUT_CYCLES = 52500,
  parameter int FILTER_LEN     = 4
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_REQ      = 3'd2,
    S_BITS     = 3'd3,
    S_ACK      = 3'd4,
    S_WAITIDLE = 3'd5
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    raw_in;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          clk_fall;

  state_t        state_q;
  logic [7:0]    data_q;
  logic          par_q;
  logic [3:0]    bitcnt_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          clk_oe_q;
  logic          dat_oe_q;

  assign raw_in   = {PS2_DAT_IN, PS2_CLK_IN};
  assign clk_fall = clk_prev_q & ~filt_q[0];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FLT_LAST) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            data_q   <= tx_data;
            par_q    <= ~^tx_data;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            dat_oe_q <= 1'b0;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            dat_oe_q <= 1'b1;
            state_q  <= S_REQ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REQ: begin
          clk_oe_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_BITS;
        end
        default: begin
          // Device-paced states share one watchdog, restarted on every fall.
          if (cnt_q == TMO_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= clk_fall ? '0 : cnt_q + 1'b1;
            case (state_q)
              S_BITS: begin
                if (clk_fall) begin
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q < 4'd8) begin
                    dat_oe_q <= ~data_q[bitcnt_q[2:0]];
                  end else if (bitcnt_q == 4'd8) begin
                    dat_oe_q <= ~par_q;
                  end else begin
                    dat_oe_q <= 1'b0;
                    state_q  <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                if (clk_fall) begin
                  if (!filt_q[1]) begin
                    state_q <= S_WAITIDLE;
                  end else begin
                    busy_q  <= 1'b0;
                    error_q <= 1'b1;
                    state_q <= S_IDLE;
                  end
                end
              end
              default: begin
                if (filt_q[0] && filt_q[1]) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Scoreboard bench for ps2_host_tx against a PS/2 keyboard model.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;
  localparam int INH  = 420;
  localparam int TMO  = 2000;
  localparam int FL   = 4;
  localparam int HALF = 140;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, clk_oe, dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-collector bus: either side may pull a line low.
  assign ps2_clk_in = ~clk_oe & dev_clk;
  assign ps2_dat_in = ~dat_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
    .CLK(CLK), .nRESET(nRESET), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error),
    .PS2_CLK_IN(ps2_clk_in), .PS2_DAT_IN(ps2_dat_in),
    .PS2_CLK_OE(clk_oe), .PS2_DAT_OE(dat_oe)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         want_done;
    bit         has_bits;
    logic [9:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  exp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame seen on the wire: 8 data bits LSB first, odd parity, stop=1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i] == 1'b1) ones++;
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  always @(negedge CLK) begin
    if (done || error) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got done=%0b error=%0b required none", done, error);
      end else begin
        mon_e = exp_q.pop_front();
        check("outcome_done", {31'd0, done}, {31'd0, mon_e.want_done});
        check("outcome_error", {31'd0, error}, {31'd0, !mon_e.want_done});
        check("busy_at_pulse", {31'd0, busy}, 32'd0);
        check("lines_released", {30'd0, clk_oe, dat_oe}, 32'd0);
        if (mon_e.has_bits) begin
          if (cap_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_bits: got nothing captured required %0h", mon_e.bits);
          end else begin
            check("frame_bits", {22'd0, cap_q.pop_front()}, {22'd0, mon_e.bits});
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_frame(input logic [7:0] b, input bit want_done, input bit push);
    exp_t e;
    int   n;
    logic first_dat, last_dat;
    e.want_done = want_done;
    e.has_bits  = 1'b1;
    e.bits      = ref_frame(b);
    @(negedge CLK);
    tx_data  = b;
    tx_start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge CLK);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    first_dat = dat_oe;
    last_dat  = 1'b0;
    while (clk_oe && n < 2000) begin
      last_dat = dat_oe;
      n++;
      @(negedge CLK);
    end
    check("clk_oe_cycles", n, INH + 1);
    check("dat_oe_inhibit", {31'd0, first_dat}, 32'd0);
    check("dat_oe_req", {31'd0, last_dat}, 32'd1);
    check("start_bit", {31'd0, dat_oe}, 32'd1);
  endtask

  task automatic device_clock(input bit ack, input int glitch_bit, input int short_bit, input bit poke);
    logic [9:0] got;
    got = '0;
    tick(100);
    for (int k = 0; k < 10; k++) begin
      if (poke && k == 2) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check("busy_hold", {31'd0, busy}, 32'd1);
      end
      dev_clk = 1'b0;
      if (k == short_bit) begin
        tick(FL);
        dev_clk = 1'b1;
        tick(20);
        got[k] = ps2_dat_in;
        tick(HALF - 20);
      end else begin
        tick(HALF);
        got[k] = ps2_dat_in;
        dev_clk = 1'b1;
        if (k == glitch_bit) begin
          tick(40);
          dev_clk = 1'b0;
          tick(2);
          dev_clk = 1'b1;
          tick(HALF - 42);
        end else begin
          tick(HALF);
        end
      end
    end
    cap_q.push_back(got);
    if (ack) dev_dat = 1'b0;
    tick(20);
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk = 1'b1;
    tick(20);
    dev_dat = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick(1);
      n++;
    end
    check("busy_release", {31'd0, busy}, 32'd0);
    tick(10);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input int glitch_bit,
                           input int short_bit, input bit poke);
    start_frame(b, ack, 1'b1);
    device_clock(ack, glitch_bit, short_bit, poke);
    wait_idle();
  endtask

  initial begin
    int n;
    tick(3);
    check("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
    check("reset_dat_oe", {31'd0, dat_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {30'd0, done, error}, 32'd0);
    nRESET = 1'b1;
    tick(5);

    run_frame(8'hED, 1'b1, -1, -1, 1'b0);
    run_frame(8'h01, 1'b1, -1, -1, 1'b0);
    run_frame(8'h00, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(8'($urandom), 1'b1, -1, -1, 1'b0);
    run_frame(8'($urandom), 1'b1, 3, -1, 1'b0);
    run_frame(8'($urandom), 1'b1, -1, 5, 1'b0);
    run_frame(8'hA3, 1'b1, -1, -1, 1'b1);
    run_frame(8'($urandom), 1'b0, -1, -1, 1'b0);

    // Device never clocks after release.
    start_frame(8'h3C, 1'b0, 1'b0);
    exp_q.push_back('{want_done: 1'b0, has_bits: 1'b0, bits: 10'd0});
    n = 0;
    while (!error && n < 3 * TMO) begin
      tick(1);
      n++;
    end
    check("timeout_window", {31'd0, (n >= TMO - 1 && n <= TMO + 1)}, 32'd1);
    wait_idle();

    // Reset in the middle of bit 5.
    start_frame(8'hC7, 1'b1, 1'b0);
    tick(100);
    for (int k = 0; k < 4; k++) begin
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(HALF);
    end
    dev_clk = 1'b0;
    tick(HALF / 2);
    #2 nRESET = 1'b0;
    #1;
    check("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, dat_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    dev_clk = 1'b1;
    tick(3);
    nRESET = 1'b1;
    tick(20);
    run_frame(8'h5A, 1'b1, -1, -1, 1'b0);

    tick(20);
    check("pending_expect", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
